ir_tx_sched: RTL and testbench

- Frame sequencer for the IRDA transmit path; replaces the fixed ROM pulse program.
- Accepts a stream of bytes over a valid/ready handshake and emits one pulse-distance-encoded Daikin-style frame per message: header, data bits LSB first, trailer mark, inter-frame gap.
- `out` drives the `in` port of the existing PWM shaper that feeds the TFDU4101 TX pin.
- `rx_mask` tells the receive decoder to ignore the transceiver's own echo while a frame is on the air.

---
 rtl/ir_pkg.sv | 28 ++
 rtl/ir_tick_timer.sv | 27 ++
 rtl/ir_tx_sched.sv | 132 +++++++++++++
 tb/tb_ir_tx_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types and default tick constants for the IR transmit frame sequencer.
// Defaults assume a 12 MHz core clock.
package ir_pkg;

    localparam int TW = 19;

    localparam int unsigned DEF_HDR_MARK   = 42000;
    localparam int unsigned DEF_HDR_SPACE  = 20400;
    localparam int unsigned DEF_BIT_MARK   = 5280;
    localparam int unsigned DEF_ONE_SPACE  = 15600;
    localparam int unsigned DEF_ZERO_SPACE = 5280;
    localparam int unsigned DEF_GAP        = 420000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_MARK,
        S_HDR_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_TRL_MARK,
        S_GAP
    } state_t;

    function automatic logic is_mark(input state_t s);
        return (s == S_HDR_MARK) || (s == S_BIT_MARK) || (s == S_TRL_MARK);
    endfunction

endpackage

// File: rtl/ir_tick_timer.sv
// Loadable down-counter that parks at zero; zero flags the final tick of a state.
// Latency: load value visible the cycle after load; no backpressure.
module ir_tick_timer
    import ir_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ir_tx_sched.sv
// Pulse-distance IR frame sequencer: header, LSB-first data bits, trailer mark, gap.
// Latency: byte transfer to first mark is 2 cycles; din_ready drops while the one-byte holding register is full.
module ir_tx_sched
    import ir_pkg::*;
#(
    parameter int unsigned HDR_MARK   = DEF_HDR_MARK,
    parameter int unsigned HDR_SPACE  = DEF_HDR_SPACE,
    parameter int unsigned BIT_MARK   = DEF_BIT_MARK,
    parameter int unsigned ONE_SPACE  = DEF_ONE_SPACE,
    parameter int unsigned ZERO_SPACE = DEF_ZERO_SPACE,
    parameter int unsigned GAP        = DEF_GAP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_last,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       out,
    output logic       busy,
    output logic       rx_mask,
    output logic       underrun
);

    state_t        state, state_nxt;
    logic [7:0]    hold, shift;
    logic          hold_last, hold_full, cur_last;
    logic [2:0]    bit_idx;
    logic          xfer, load_byte, shift_en, und_nxt;
    logic          tmr_load, tmr_zero;
    logic [TW-1:0] tmr_val;

    assign xfer = din_valid & din_ready;

    ir_tick_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt = state;
        load_byte = 1'b0;
        shift_en  = 1'b0;
        und_nxt   = 1'b0;
        case (state)
            S_IDLE:      if (hold_full) begin
                             state_nxt = S_HDR_MARK;
                             load_byte = 1'b1;
                         end
            S_HDR_MARK:  if (tmr_zero) state_nxt = S_HDR_SPACE;
            S_HDR_SPACE: if (tmr_zero) state_nxt = S_BIT_MARK;
            S_BIT_MARK:  if (tmr_zero) state_nxt = S_BIT_SPACE;
            S_BIT_SPACE: if (tmr_zero) begin
                             if (bit_idx != 3'd7) begin
                                 shift_en  = 1'b1;
                                 state_nxt = S_BIT_MARK;
                             end else if (cur_last) begin
                                 state_nxt = S_TRL_MARK;
                             end else if (hold_full) begin
                                 load_byte = 1'b1;
                                 state_nxt = S_BIT_MARK;
                             end else begin
                                 und_nxt   = 1'b1;
                                 state_nxt = S_TRL_MARK;
                             end
                         end
            S_TRL_MARK:  if (tmr_zero) state_nxt = S_GAP;
            S_GAP:       if (tmr_zero) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase

        // Every exit changes state, so a state change is exactly a state entry.
        tmr_load = (state_nxt != state);
        case (state_nxt)
            S_HDR_MARK:  tmr_val = TW'(HDR_MARK - 1);
            S_HDR_SPACE: tmr_val = TW'(HDR_SPACE - 1);
            S_BIT_MARK:  tmr_val = TW'(BIT_MARK - 1);
            S_BIT_SPACE: tmr_val = shift[0] ? TW'(ONE_SPACE - 1) : TW'(ZERO_SPACE - 1);
            S_TRL_MARK:  tmr_val = TW'(BIT_MARK - 1);
            S_GAP:       tmr_val = TW'(GAP - 1);
            default:     tmr_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            hold      <= '0;
            hold_last <= 1'b0;
            hold_full <= 1'b0;
            shift     <= '0;
            cur_last  <= 1'b0;
            bit_idx   <= '0;
            din_ready <= 1'b1;
            out       <= 1'b0;
            busy      <= 1'b0;
            rx_mask   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (xfer) begin
                hold      <= din;
                hold_last <= din_last;
                hold_full <= 1'b1;
            end else if (load_byte) begin
                hold_full <= 1'b0;
            end
            // A load and a transfer never coincide: a load needs hold_full, a transfer needs it clear.
            din_ready <= ~(xfer | (hold_full & ~load_byte));

            if (load_byte) begin
                shift    <= hold;
                cur_last <= hold_last;
                bit_idx  <= '0;
            end else if (shift_en) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 3'd1;
            end

            // Outputs follow the next state so they line up with the state register.
            out      <= is_mark(state_nxt);
            busy     <= (state_nxt != S_IDLE);
            rx_mask  <= (state_nxt != S_IDLE);
            underrun <= und_nxt;
        end
    end

endmodule

// File: tb/tb_ir_tx_sched.sv
// Self-checking bench: frames are compared against a mark/space waveform built from the byte list.
module tb_ir_tx_sched;

    localparam int HM = 8, HS = 4, BM = 2, OS = 6, ZS = 2, GP = 10;

    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       reset, din_last, din_valid;
    logic [7:0] din;
    logic       din_ready, out, busy, rx_mask, underrun;

    int  n_checks = 0, n_pass = 0;
    int  cyc = 0;
    bit  cap_q [$];
    bit  exp_q [$];
    int  und_q [$];
    int  xfer_cyc [$];
    int  rxm_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ir_tx_sched #(
        .HDR_MARK(HM), .HDR_SPACE(HS), .BIT_MARK(BM),
        .ONE_SPACE(OS), .ZERO_SPACE(ZS), .GAP(GP)
    ) dut (
        .clk(clk), .reset(reset), .din(din), .din_last(din_last),
        .din_valid(din_valid), .din_ready(din_ready), .out(out),
        .busy(busy), .rx_mask(rx_mask), .underrun(underrun)
    );

    // Record the envelope of every busy cycle plus where underrun pulses land.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) begin
                cap_q.push_back(out);
                if (underrun) und_q.push_back(cap_q.size() - 1);
            end else if (underrun) begin
                und_q.push_back(-1);
            end
            if (rx_mask !== busy) rxm_err++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void build_exp(input bq_t bytes);
        exp_q.delete();
        repeat (HM) exp_q.push_back(1'b1);
        repeat (HS) exp_q.push_back(1'b0);
        foreach (bytes[i]) begin
            for (int k = 0; k < 8; k++) begin
                repeat (BM) exp_q.push_back(1'b1);
                repeat (bytes[i][k] ? OS : ZS) exp_q.push_back(1'b0);
            end
        end
        repeat (BM) exp_q.push_back(1'b1);
        repeat (GP) exp_q.push_back(1'b0);
    endfunction

    function automatic int bit_space_off(input logic [7:0] v, input int k);
        int o = HM + HS;
        for (int i = 0; i < k; i++) o += BM + (v[i] ? OS : ZS);
        return o + BM;
    endfunction

    function automatic void clear_cap();
        cap_q.delete();
        und_q.delete();
        rxm_err = 0;
    endfunction

    task automatic send_bytes(input bq_t bytes, input bit last, input int gap_max);
        int t;
        @(posedge clk); #1;
        foreach (bytes[i]) begin
            din_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            din       = bytes[i];
            din_last  = last && (i == bytes.size() - 1);
            din_valid = 1'b1;
            t = 0;
            while (!din_ready && t < 2000) begin @(posedge clk); #1; t++; end
            if (t >= 2000) begin
                check("ready_timeout", 0, 1);
                din_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            xfer_cyc.push_back(cyc);
            check("ready_after_xfer", din_ready, 0);
        end
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic wait_busy(input logic level, input int bound);
        int t = 0;
        while (busy !== level && t < bound) begin @(negedge clk); t++; end
        if (t >= bound) check("busy_timeout", busy, level);
    endtask

    task automatic check_frame(input string tag, input int und_idx);
        int first_bad = -1;
        check({tag, "_len"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            if (cap_q[i] !== exp_q[i] && first_bad < 0) first_bad = i;
        check({tag, "_first_wave_diff"}, first_bad, -1);
        check({tag, "_underrun_cnt"}, und_q.size(), (und_idx >= 0) ? 1 : 0);
        if (und_idx >= 0 && und_q.size() > 0) check({tag, "_underrun_pos"}, und_q[0], und_idx);
        check({tag, "_rx_mask"}, rxm_err, 0);
        clear_cap();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t b;
        int  off, t, seen;
        logic [7:0] v;

        reset = 1'b1; din = '0; din_last = 1'b0; din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out", out, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_mask", rx_mask, 0);
        check("rst_underrun", underrun, 0);
        check("rst_din_ready", din_ready, 1);
        clear_cap();

        // Single byte frame.
        b = '{8'hA5};
        build_exp(b);
        send_bytes(b, 1'b1, 0);
        wait_busy(1'b1, 20);
        wait_busy(1'b0, 500);
        check_frame("single_a5", -1);

        // Two bytes back to back form one 16-bit frame.
        b = '{8'h01, 8'h80};
        build_exp(b);
        send_bytes(b, 1'b1, 0);
        wait_busy(1'b1, 20);
        wait_busy(1'b0, 500);
        check_frame("b2b_01_80", -1);

        // Missing follow-on byte: trailer right after bit 7, one underrun pulse at trailer start.
        b = '{8'hFF};
        build_exp(b);
        send_bytes(b, 1'b0, 0);
        wait_busy(1'b1, 20);
        wait_busy(1'b0, 500);
        check_frame("underrun_ff", exp_q.size() - BM - GP);

        // Valid held continuously across four random bytes.
        b.delete();
        repeat (4) b.push_back(8'($urandom_range(0, 255)));
        build_exp(b);
        xfer_cyc.delete();
        send_bytes(b, 1'b1, 0);
        check("bp_first_gap", xfer_cyc[1] - xfer_cyc[0], 2);
        wait_busy(1'b1, 20);
        wait_busy(1'b0, 1000);
        check_frame("backpressure", -1);

        // Random frames with random idle gaps between byte offers.
        for (int r = 0; r < 6; r++) begin
            b.delete();
            repeat ($urandom_range(1, 3)) b.push_back(8'($urandom_range(0, 255)));
            build_exp(b);
            send_bytes(b, 1'b1, 3);
            wait_busy(1'b1, 20);
            wait_busy(1'b0, 1000);
            check_frame($sformatf("rand%0d", r), -1);
        end

        // Reset during the space of bit 3 with a second byte waiting in hold.
        v = 8'h5A;
        b = '{v, 8'h33};
        off = bit_space_off(v, 3);
        send_bytes(b, 1'b1, 0);
        t = 0;
        while (cap_q.size() < off + 2 && t < 500) begin @(negedge clk); #1; t++; end
        check("mid_rst_reached", (t < 500), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out", out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_din_ready", din_ready, 1);
        check("mid_rst_underrun", underrun, 0);
        @(posedge clk); #1 reset = 1'b0;
        seen = 0;
        repeat (6) begin @(negedge clk); if (busy !== 1'b0) seen++; end
        check("mid_rst_hold_dropped", seen, 0);
        clear_cap();
        b = '{8'h00};
        build_exp(b);
        send_bytes(b, 1'b1, 0);
        wait_busy(1'b1, 20);
        wait_busy(1'b0, 500);
        check_frame("post_rst_00", -1);

        // Next frame's byte offered during GAP starts a new header right after the idle cycle.
        b = '{8'($urandom_range(0, 255))};
        build_exp(b);
        send_bytes(b, 1'b1, 0);
        wait_busy(1'b1, 20);
        t = 0;
        while (cap_q.size() < exp_q.size() - GP + 2 && t < 500) begin @(negedge clk); #1; t++; end
        b = '{8'($urandom_range(0, 255))};
        send_bytes(b, 1'b1, 0);
        wait_busy(1'b0, 500);
        check_frame("gap_queue_first", -1);
        @(negedge clk);
        check("gap_restart_busy", busy, 1);
        check("gap_restart_out", out, 1);
        build_exp(b);
        wait_busy(1'b0, 500);
        check_frame("gap_queue_second", -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
